// File: rtl/vga_sram_pattern_writer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_sram_pattern_writer_if : SRAM write-request bus (addr/data/valid/ready)
// Rev 1.0
// ------------------------------------------------------------------
interface vga_sram_pattern_writer_if #(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 16
);
   logic [ADDR_BITS-1:0] addr;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (
      output addr,
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  addr,
      input  data,
      input  valid,
      output ready
   );
endinterface
`default_nettype wire

// File: rtl/vga_sram_pattern_writer.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_sram_pattern_writer : streams one frame of a test pattern to SRAM
// Rev 1.0
// ------------------------------------------------------------------
module vga_sram_pattern_writer #(
   parameter int H_VISIBLE     = 640,
   parameter int V_VISIBLE     = 480,
   parameter int ADDR_BITS     = 20,
   parameter int DATA_BITS     = 16,
   parameter int CHECKER_SHIFT = 5
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  start,
   input  wire logic [1:0]            pattern,
   input  wire logic [11:0]           color,
   output logic                       busy,
   output logic                       done,
   vga_sram_pattern_writer_if.master  bus
);

   localparam int COL_W = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
   localparam int ROW_W = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

   localparam logic [COL_W-1:0] C_COL_LAST       = COL_W'(H_VISIBLE - 1);
   localparam logic [ROW_W-1:0] C_ROW_LAST       = ROW_W'(V_VISIBLE - 1);
   localparam logic [COL_W-1:0] C_COL_THIRD      = COL_W'(H_VISIBLE / 3);
   localparam logic [COL_W-1:0] C_COL_TWO_THIRDS = COL_W'(2 * (H_VISIBLE / 3));
   localparam logic [ROW_W-1:0] C_ROW_THIRD      = ROW_W'(V_VISIBLE / 3);
   localparam logic [ROW_W-1:0] C_ROW_TWO_THIRDS = ROW_W'(2 * (V_VISIBLE / 3));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [COL_W-1:0]     r_col;
   logic [ROW_W-1:0]     r_row;
   logic [ADDR_BITS-1:0] r_addr;
   logic [1:0]           r_mode;
   logic [11:0]          r_color;

   logic                 w_run;
   logic                 w_xfer;
   logic                 w_accept;
   logic                 w_last_col;
   logic                 w_last_pix;
   logic [COL_W-1:0]     w_col_blk;
   logic [ROW_W-1:0]     w_row_blk;
   logic [11:0]          w_pix;
   logic [DATA_BITS-1:0] w_word;

   assign w_run      = (r_state == S_RUN);
   assign w_xfer     = w_run && bus.ready;
   assign w_accept   = start && !w_run;
   assign w_last_col = (r_col == C_COL_LAST);
   assign w_last_pix = w_last_col && (r_row == C_ROW_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.ready && w_last_pix) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Raster position; addr tracks row*H_VISIBLE+col by stepping once per transfer.
   // The final transfer leaves the counters parked on the last pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col   <= '0;
         r_row   <= '0;
         r_addr  <= '0;
         r_mode  <= 2'd0;
         r_color <= 12'h000;
      end else if (w_accept) begin
         r_col   <= '0;
         r_row   <= '0;
         r_addr  <= '0;
         r_mode  <= pattern;
         r_color <= color;
      end else if (w_xfer && !w_last_pix) begin
         r_addr <= r_addr + 1'b1;
         if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign w_col_blk = r_col >> CHECKER_SHIFT;
   assign w_row_blk = r_row >> CHECKER_SHIFT;

   always_comb begin
      w_pix = 12'h000;
      case (r_mode)
         2'd0: begin
            if (r_col < C_COL_THIRD)           w_pix = 12'hF00;
            else if (r_col < C_COL_TWO_THIRDS) w_pix = 12'h0F0;
            else                               w_pix = 12'h00F;
         end
         2'd1: begin
            if (r_row < C_ROW_THIRD)           w_pix = 12'hF00;
            else if (r_row < C_ROW_TWO_THIRDS) w_pix = 12'h0F0;
            else                               w_pix = 12'h00F;
         end
         2'd2: begin
            w_pix = (w_col_blk[0] ^ w_row_blk[0]) ? 12'hFFF : 12'h000;
         end
         default: begin
            w_pix = r_color;
         end
      endcase
   end

   // RGB444 occupies the top of the word; any extra low bits stay zero.
   generate
      if (DATA_BITS > 12) begin : g_pad
         assign w_word = {w_pix, {(DATA_BITS-12){1'b0}}};
      end else begin : g_exact
         assign w_word = w_pix;
      end
   endgenerate

   assign bus.valid = w_run;
   assign bus.addr  = r_addr;
   assign bus.data  = w_run ? w_word : '0;
   assign busy      = w_run;
   assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_vga_sram_pattern_writer.sv
`default_nettype none
// Directed bench for vga_sram_pattern_writer with a frame-level reference model.
module tb_vga_sram_pattern_writer;

   localparam int H    = 8;
   localparam int V    = 4;
   localparam int AB   = 20;
   localparam int DB   = 16;
   localparam int CS   = 1;
   localparam int NPIX = H * V;

   logic        clk     = 1'b0;
   logic        reset   = 1'b1;
   logic        start   = 1'b0;
   logic [1:0]  pattern = 2'd0;
   logic [11:0] color   = 12'h000;
   logic        busy;
   logic        done;

   vga_sram_pattern_writer_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus_if();

   vga_sram_pattern_writer #(
      .H_VISIBLE    (H),
      .V_VISIBLE    (V),
      .ADDR_BITS    (AB),
      .DATA_BITS    (DB),
      .CHECKER_SHIFT(CS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .pattern(pattern),
      .color  (color),
      .busy   (busy),
      .done   (done),
      .bus    (bus_if.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a fill is a walk over pixel index 0..NPIX-1.
   bit          m_run   = 1'b0;
   bit          m_done  = 1'b0;
   int          m_n     = 0;
   logic [1:0]  m_mode  = 2'd0;
   logic [11:0] m_color = 12'h000;

   logic [15:0] seen [NPIX];
   int          xfers = 0;
   logic [7:0]  lfsr  = 8'hA5;

   function automatic logic [15:0] exp_word(logic [1:0] mode, logic [11:0] rgb, int col, int row);
      logic [11:0] p;
      case (mode)
         2'd0:    p = (col < H/3) ? 12'hF00 : (col < 2*(H/3)) ? 12'h0F0 : 12'h00F;
         2'd1:    p = (row < V/3) ? 12'hF00 : (row < 2*(V/3)) ? 12'h0F0 : 12'h00F;
         2'd2:    p = ((((col >> CS) ^ (row >> CS)) & 1) == 1) ? 12'hFFF : 12'h000;
         default: p = rgb;
      endcase
      return {p, 4'h0};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_run  = 1'b0;
         m_done = 1'b0;
         m_n    = 0;
      end else if (m_run) begin
         if (bus_if.ready) begin
            if (m_n == NPIX - 1) begin
               m_run  = 1'b0;
               m_done = 1'b1;
            end else begin
               m_n++;
            end
         end
      end else if (start) begin
         m_run   = 1'b1;
         m_done  = 1'b0;
         m_n     = 0;
         m_mode  = pattern;
         m_color = color;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         check("rst_flags", {29'd0, bus_if.valid, busy, done}, 32'd0);
         check("rst_addr",  32'(bus_if.addr), 32'd0);
         check("rst_data",  32'(bus_if.data), 32'd0);
      end else begin
         check("flags", {29'd0, bus_if.valid, busy, done}, {29'd0, m_run, m_run, m_done});
         if (m_run) begin
            check("addr", 32'(bus_if.addr), 32'(m_n));
            check("data", 32'(bus_if.data), 32'(exp_word(m_mode, m_color, m_n % H, m_n / H)));
         end
         if (bus_if.valid && bus_if.ready) begin
            xfers++;
            if (int'(bus_if.addr) < NPIX) seen[int'(bus_if.addr)] = bus_if.data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_seen();
      for (int i = 0; i < NPIX; i++) seen[i] = 16'hDEAD;
      xfers = 0;
   endtask

   task automatic pulse_start(logic [1:0] p, logic [11:0] c);
      pattern = p;
      color   = c;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic run_to_done(string tag, bit rnd);
      int budget = 0;
      while (!m_done && budget < 500) begin
         if (rnd) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus_if.ready = lfsr[0];
         end else begin
            bus_if.ready = 1'b1;
         end
         tick();
         budget++;
      end
      if (!m_done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: fill not finished after %0d cycles", tag, budget);
      end
      bus_if.ready = 1'b1;
      check({tag, "_xfers"}, 32'(xfers), 32'(NPIX));
      check({tag, "_done"},  {31'd0, done}, 32'd1);
   endtask

   initial begin
      bus_if.ready = 1'b1;
      clear_seen();
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Vertical bars, ready always high.
      clear_seen();
      pulse_start(2'd0, 12'h000);
      run_to_done("vbars", 1'b0);
      check("vbars_px0",  32'(seen[0]),  32'h0000F000);
      check("vbars_px1",  32'(seen[1]),  32'h0000F000);
      check("vbars_px3",  32'(seen[3]),  32'h00000F00);
      check("vbars_px7",  32'(seen[7]),  32'h000000F0);
      check("vbars_px31", 32'(seen[31]), 32'h000000F0);

      // Restart from DONE with horizontal bars.
      clear_seen();
      pulse_start(2'd1, 12'h000);
      check("hbars_done_clear", {31'd0, done}, 32'd0);
      check("hbars_addr0", 32'(bus_if.addr), 32'd0);
      run_to_done("hbars", 1'b0);
      check("hbars_px0",  32'(seen[0]),  32'h0000F000);
      check("hbars_px8",  32'(seen[8]),  32'h00000F00);
      check("hbars_px16", 32'(seen[16]), 32'h000000F0);
      check("hbars_px31", 32'(seen[31]), 32'h000000F0);

      // Checker with back-pressure.
      clear_seen();
      pulse_start(2'd2, 12'h000);
      run_to_done("checker", 1'b1);
      check("checker_px9", 32'(seen[9]), 32'h00000000);
      check("checker_px2", 32'(seen[2]), 32'h0000FFF0);
      check("checker_px0", 32'(seen[0]), 32'h00000000);

      // Solid colour with a start pulse in the middle of the fill.
      clear_seen();
      pulse_start(2'd3, 12'hA5C);
      for (int i = 0; i < 10; i++) tick();
      pulse_start(2'd0, 12'h123);
      run_to_done("solid", 1'b0);
      check("solid_px0",  32'(seen[0]),  32'h0000A5C0);
      check("solid_px11", 32'(seen[11]), 32'h0000A5C0);
      check("solid_px31", 32'(seen[31]), 32'h0000A5C0);

      // Reset while address 13 is on the bus.
      clear_seen();
      pulse_start(2'd0, 12'h000);
      for (int i = 0; i < 100 && !(m_run && m_n == 13); i++) tick();
      check("abort_at13", 32'(bus_if.addr), 32'd13);
      reset = 1'b1;
      #1;
      check("abort_addr",  32'(bus_if.addr), 32'd0);
      check("abort_flags", {29'd0, bus_if.valid, busy, done}, 32'd0);
      check("abort_xfers", 32'(xfers), 32'd13);
      tick();
      reset = 1'b0;
      tick();
      clear_seen();
      pulse_start(2'd0, 12'h000);
      check("restart_addr0", 32'(bus_if.addr), 32'd0);
      run_to_done("restart", 1'b0);
      check("restart_px0", 32'(seen[0]), 32'h0000F000);

      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/vga_sram_pattern_writer.md
VGA_SRAM_PATTERN_WRITER -- requirements
Module: vga_sram_pattern_writer

Interface
REQ-001 The module SHALL have parameter H_VISIBLE, default 640, meaning pixels per line.
REQ-002 The module SHALL have parameter V_VISIBLE, default 480, meaning lines per frame.
REQ-003 The module SHALL have parameter ADDR_BITS, default 20, meaning SRAM address width.
REQ-004 The module SHALL have parameter DATA_BITS, default 16, meaning SRAM word width; minimum 12.
REQ-005 The module SHALL have parameter CHECKER_SHIFT, default 5, meaning log2 of the checker square size in pixels.
REQ-006 The module SHALL have port clk, input, 1 bit: clock.
REQ-007 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The module SHALL have port start, input, 1 bit: single-cycle request to fill one frame.
REQ-009 The module SHALL have port pattern, input, 2 bits: fill mode, sampled on accepted start.
REQ-010 The module SHALL have port color, input, 12 bits: RGB444 for solid mode, sampled on accepted start.
REQ-011 The module SHALL have port addr, output, ADDR_BITS: SRAM word address of the current pixel.
REQ-012 The module SHALL have port data, output, DATA_BITS: pixel word for addr.
REQ-013 The module SHALL have port valid, output, 1 bit: addr/data present a write request.
REQ-014 The module SHALL have port ready, input, 1 bit: downstream SRAM writer accepts the request.
REQ-015 The module SHALL have port busy, output, 1 bit: a fill is in progress.
REQ-016 The module SHALL have port done, output, 1 bit: the last fill completed.

Function
REQ-017 The module SHALL implement states IDLE, RUN and DONE.
REQ-018 On start in IDLE or DONE, the module SHALL latch pattern and color, clear column/row/addr to 0, clear done, and enter RUN on the next edge.
REQ-019 The module SHALL ignore start while in RUN.
REQ-020 In RUN, valid and busy SHALL be 1; in IDLE and DONE, valid and busy SHALL be 0.
REQ-021 A transfer SHALL occur on a rising edge with valid && ready; without ready, addr and data SHALL hold stable.
REQ-022 On each transfer, column SHALL increment; at column == H_VISIBLE-1 it SHALL wrap to 0 and row SHALL increment.
REQ-023 addr SHALL equal row*H_VISIBLE + column, maintained by incremental add, with no multiplier.
REQ-024 The transfer at column == H_VISIBLE-1, row == V_VISIBLE-1 SHALL enter DONE, set done=1, and drop valid on the next cycle.
REQ-025 Exactly H_VISIBLE*V_VISIBLE transfers SHALL occur per fill, with no duplicate or skipped address.
REQ-026 done SHALL remain 1 until the next accepted start or reset.
REQ-027 data[DATA_BITS-1 -: 12] SHALL be R[3:0],G[3:0],B[3:0]; all lower bits SHALL be 0.
REQ-028 Pattern 0 (vertical bars) SHALL be red for column < H_VISIBLE/3, green for column < 2*(H_VISIBLE/3), else blue; each component is 4'hF when on.
REQ-029 Pattern 1 (horizontal bars) SHALL apply the same rule as pattern 0 using row and V_VISIBLE.
REQ-030 Pattern 2 (checker) SHALL be 12'hFFF when ((column>>CHECKER_SHIFT) ^ (row>>CHECKER_SHIFT)) bit 0 is 1, else 12'h000.
REQ-031 Pattern 3 (solid) SHALL use the latched color for every pixel.
REQ-032 data SHALL be a function of the current column, row and latched mode only, and SHALL be valid in the same cycle as addr.

Reset
REQ-033 While reset is high, outputs SHALL be addr=0, data=0, valid=0, busy=0, done=0; column and row SHALL be 0 and state SHALL be IDLE.
REQ-034 Reset asserted mid-fill SHALL abort immediately; no transfer SHALL be counted in that cycle, and a new start SHALL begin again at addr 0.

Verification (H_VISIBLE=8, V_VISIBLE=4, CHECKER_SHIFT=1, DATA_BITS=16)
REQ-035 Scenario: start, pattern=0, ready=1 -> 32 transfers, addr 0..31; data 0xF000 for columns 0-1, 0x0F00 for columns 2-3, 0x00F0 for columns 4-7; done=1 one cycle after addr 31.
REQ-036 Scenario: pattern=2, ready toggling pseudo-randomly -> addr/data stable while ready=0; addr 9 (row 1, column 1) gives data 0x0000, addr 2 gives 0xFFF0; still 32 transfers.
REQ-037 Scenario: pattern=3, color=12'hA5C -> every word is 0xA5C0; start pulsed mid-fill is ignored, and addr continues sequentially.
REQ-038 Scenario: reset asserted at addr 13 -> all outputs 0 in the same cycle; a subsequent start resumes from addr 0.
REQ-039 Scenario: start in DONE with pattern=1 -> done clears, addr restarts at 0; rows 0-0 are red, row 1 green, rows 2-3 blue (V_VISIBLE/3=1).
